// File: rtl/axi4_lite_master_arb_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_master_arb_if : request/response ports and AXI4-Lite bus   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface axi4_lite_master_arb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_is_write;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic [1:0]            rsp_resp;

  logic [ADDR_WIDTH-1:0] M_AWADDR;
  logic                  M_AWVALID;
  logic                  M_AWREADY;
  logic [DATA_WIDTH-1:0] M_WDATA;
  logic [STRB_WIDTH-1:0] M_WSTRB;
  logic                  M_WVALID;
  logic                  M_WREADY;
  logic [1:0]            M_BRESP;
  logic                  M_BVALID;
  logic                  M_BREADY;
  logic [ADDR_WIDTH-1:0] M_ARADDR;
  logic                  M_ARVALID;
  logic                  M_ARREADY;
  logic [DATA_WIDTH-1:0] M_RDATA;
  logic [1:0]            M_RRESP;
  logic                  M_RVALID;
  logic                  M_RREADY;

  modport master (
    input  wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready,
           M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID,
    output wr_ready, rd_ready, rsp_valid, rsp_is_write, rsp_rdata, rsp_resp,
           M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY
  );

  modport slave (
    output wr_valid, wr_addr, wr_data, wr_strb, rd_valid, rd_addr, rsp_ready,
           M_AWREADY, M_WREADY, M_BRESP, M_BVALID, M_ARREADY, M_RDATA, M_RRESP, M_RVALID,
    input  wr_ready, rd_ready, rsp_valid, rsp_is_write, rsp_rdata, rsp_resp,
           M_AWADDR, M_AWVALID, M_WDATA, M_WSTRB, M_WVALID, M_BREADY,
           M_ARADDR, M_ARVALID, M_RREADY
  );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi4_lite_master_arb : single-outstanding AXI4-Lite master with      |
// | round-robin write/read arbitration. Revision 1.0                     |
// +----------------------------------------------------------------------+
module axi4_lite_master_arb #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  wire                    ACLK,
  input  wire                    ARESETN,
  axi4_lite_master_arb_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_REQ  = 3'd1,
    S_WR_RESP = 3'd2,
    S_RD_REQ  = 3'd3,
    S_RD_DATA = 3'd4,
    S_RSP     = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  prefer_write_q, prefer_write_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic                  awvalid_q, awvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_is_write_q, rsp_is_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;

  logic w_idle;
  logic w_wr_grant;
  logic w_rd_grant;
  logic w_aw_done;
  logic w_w_done;

  assign w_idle       = (state_q == S_IDLE);
  assign bus.wr_ready = w_idle && (!bus.rd_valid || prefer_write_q);
  assign bus.rd_ready = w_idle && (!bus.wr_valid || !prefer_write_q);
  assign w_wr_grant   = bus.wr_valid && bus.wr_ready;
  assign w_rd_grant   = bus.rd_valid && bus.rd_ready;
  // A channel counts as done once its valid has dropped or is handshaking now.
  assign w_aw_done    = !awvalid_q || bus.M_AWREADY;
  assign w_w_done     = !wvalid_q  || bus.M_WREADY;

  always_comb begin
    state_d        = state_q;
    prefer_write_d = prefer_write_q;
    awaddr_d       = awaddr_q;
    awvalid_d      = awvalid_q;
    wdata_d        = wdata_q;
    wstrb_d        = wstrb_q;
    wvalid_d       = wvalid_q;
    bready_d       = bready_q;
    araddr_d       = araddr_q;
    arvalid_d      = arvalid_q;
    rready_d       = rready_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_is_write_d = rsp_is_write_q;
    rsp_rdata_d    = rsp_rdata_q;
    rsp_resp_d     = rsp_resp_q;
    case (state_q)
      S_IDLE: begin
        if (w_wr_grant) begin
          awaddr_d       = bus.wr_addr;
          wdata_d        = bus.wr_data;
          wstrb_d        = bus.wr_strb;
          awvalid_d      = 1'b1;
          wvalid_d       = 1'b1;
          prefer_write_d = 1'b0;
          state_d        = S_WR_REQ;
        end else if (w_rd_grant) begin
          araddr_d       = bus.rd_addr;
          arvalid_d      = 1'b1;
          prefer_write_d = 1'b1;
          state_d        = S_RD_REQ;
        end
      end
      S_WR_REQ: begin
        if (awvalid_q && bus.M_AWREADY) awvalid_d = 1'b0;
        if (wvalid_q && bus.M_WREADY)   wvalid_d  = 1'b0;
        if (w_aw_done && w_w_done) begin
          bready_d = 1'b1;
          state_d  = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        if (bus.M_BVALID) begin
          bready_d       = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_is_write_d = 1'b1;
          rsp_rdata_d    = '0;
          rsp_resp_d     = bus.M_BRESP;
          state_d        = S_RSP;
        end
      end
      S_RD_REQ: begin
        if (bus.M_ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (bus.M_RVALID) begin
          rready_d       = 1'b0;
          rsp_valid_d    = 1'b1;
          rsp_is_write_d = 1'b0;
          rsp_rdata_d    = bus.M_RDATA;
          rsp_resp_d     = bus.M_RRESP;
          state_d        = S_RSP;
        end
      end
      S_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q        <= S_IDLE;
      prefer_write_q <= 1'b1;
      awaddr_q       <= '0;
      awvalid_q      <= 1'b0;
      wdata_q        <= '0;
      wstrb_q        <= '0;
      wvalid_q       <= 1'b0;
      bready_q       <= 1'b0;
      araddr_q       <= '0;
      arvalid_q      <= 1'b0;
      rready_q       <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_is_write_q <= 1'b0;
      rsp_rdata_q    <= '0;
      rsp_resp_q     <= 2'b00;
    end else begin
      state_q        <= state_d;
      prefer_write_q <= prefer_write_d;
      awaddr_q       <= awaddr_d;
      awvalid_q      <= awvalid_d;
      wdata_q        <= wdata_d;
      wstrb_q        <= wstrb_d;
      wvalid_q       <= wvalid_d;
      bready_q       <= bready_d;
      araddr_q       <= araddr_d;
      arvalid_q      <= arvalid_d;
      rready_q       <= rready_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_is_write_q <= rsp_is_write_d;
      rsp_rdata_q    <= rsp_rdata_d;
      rsp_resp_q     <= rsp_resp_d;
    end
  end

  assign bus.M_AWADDR     = awaddr_q;
  assign bus.M_AWVALID    = awvalid_q;
  assign bus.M_WDATA      = wdata_q;
  assign bus.M_WSTRB      = wstrb_q;
  assign bus.M_WVALID     = wvalid_q;
  assign bus.M_BREADY     = bready_q;
  assign bus.M_ARADDR     = araddr_q;
  assign bus.M_ARVALID    = arvalid_q;
  assign bus.M_RREADY     = rready_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_is_write = rsp_is_write_q;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_resp     = rsp_resp_q;

endmodule
`default_nettype wire
